// File: rtl/rad4_booth_decoder_acc.sv
// Radix-4 Booth digit decoder + shift-accumulator: N-bit signed mcand times a D=N/2 digit stream, 2N-bit product.
// Latency: one cycle per accepted digit; prod_valid rises the cycle after the last (D-1) digit is accepted.
// Backpressure: dig_ready only in ACCUM (dig_valid gaps stall freely); product is held in DONE until prod_ready.
module rad4_booth_decoder_acc #(
    parameter int N = 8                      // even, >= 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     mcand,
    output logic             busy,
    input  logic             dig_valid,
    output logic             dig_ready,
    input  logic             si,
    input  logic             di,
    input  logic             ni,
    output logic [2*N-1:0]   prod,
    output logic             prod_valid,
    input  logic             prod_ready,
    output logic             err
);

    localparam int D  = N / 2;
    localparam int W  = 2 * N;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    mcand_q;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic            err_q;

    logic            start_acc;
    logic            dig_acc;
    logic            last_dig;
    logic [W-1:0]    sel;
    logic [W-1:0]    part;
    logic [CW:0]     shamt;

    assign start_acc  = (state == IDLE) && start;
    assign dig_acc    = (state == ACCUM) && dig_valid;
    assign last_dig   = (cnt == CW'(D - 1));
    assign shamt      = {cnt, 1'b0};

    assign busy       = (state != IDLE);
    assign dig_ready  = (state == ACCUM);
    assign prod_valid = (state == DONE);
    // acc is frozen outside ACCUM, so it doubles as the held product register
    assign prod       = acc;
    assign err        = err_q;

    // Digit decode: magnitude select, then optional negation; the illegal
    // si=di=1 code and the signed zero (0,0,1) both fall through to zero.
    always_comb begin
        sel = '0;
        case ({si, di})
            2'b10:   sel = mcand_q;
            2'b01:   sel = mcand_q << 1;
            default: sel = '0;
        endcase
        part = ni ? (~sel + W'(1)) : sel;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start only counts in IDLE, prod_ready only in DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)              state_nxt = ACCUM;
            ACCUM:   if (dig_valid && last_dig) state_nxt = DONE;
            DONE:    if (prod_ready)         state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on start, weighted accumulate on each accepted digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else if (start_acc) begin
            mcand_q <= {{N{mcand[N-1]}}, mcand};
            acc     <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else if (dig_acc) begin
            acc     <= acc + (part << shamt);
            cnt     <= last_dig ? '0 : cnt + CW'(1);
            err_q   <= err_q | (si & di);
        end
    end

endmodule

// File: tb/tb_rad4_booth_decoder_acc.sv
module tb_rad4_booth_decoder_acc;

    localparam int N = 8;
    localparam int D = N / 2;

    typedef logic [D-1:0][2:0] dig_t;   // per digit {si,di,ni}, index = position

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   mcand;
    logic           busy;
    logic           dig_valid;
    logic           dig_ready;
    logic           si, di, ni;
    logic [2*N-1:0] prod;
    logic           prod_valid;
    logic           prod_ready;
    logic           err;

    int n_tests = 0;
    int n_fail  = 0;

    rad4_booth_decoder_acc #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mcand      (mcand),
        .busy       (busy),
        .dig_valid  (dig_valid),
        .dig_ready  (dig_ready),
        .si         (si),
        .di         (di),
        .ni         (ni),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Signed digit value -> {si,di,ni}
    function automatic logic [2:0] enc(input int v);
        case (v)
            1:       return 3'b100;
            -1:      return 3'b101;
            2:       return 3'b010;
            -2:      return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Ideal radix-4 Booth recoding: d_k = -2*b[2k+1] + b[2k] + b[2k-1]
    function automatic dig_t recode(input logic [N-1:0] m);
        dig_t t;
        for (int k = 0; k < D; k++) begin
            int b1 = int'(m[2*k+1]);
            int b0 = int'(m[2*k]);
            int bm = (k == 0) ? 0 : int'(m[2*k-1]);
            t[k] = enc(-2 * b1 + b0 + bm);
        end
        return t;
    endfunction

    // Product implied by a digit list, illegal digits contributing nothing
    function automatic logic [15:0] digit_prod(input logic [N-1:0] mc, input dig_t t);
        int s = 0;
        int m = int'($signed(mc));
        for (int k = 0; k < D; k++) begin
            int mag = (t[k][2:1] == 2'b10) ? 1 : (t[k][2:1] == 2'b01) ? 2 : 0;
            int v   = t[k][0] ? -mag : mag;
            s += v * m * (4 ** k);
        end
        return s[15:0];
    endfunction

    task automatic idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_drdy"},  32'(dig_ready), 32'd0);
        check({tag, "_pvld"},  32'(prod_valid), 32'd0);
        check({tag, "_prod"},  32'(prod), 32'd0);
        check({tag, "_err"},   32'(err), 32'd0);
    endtask

    // Full operation; called and returns at a negedge with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [N-1:0] mc, input dig_t t,
                          input logic [15:0] exp_prod, input logic exp_err,
                          input int max_gap, input int hold, input bit noise, input bit both);
        logic [15:0] held;
        mcand = mc;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mcand = N'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < D; k++) begin
            int g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int j = 0; j < g; j++) begin
                {si, di, ni} = 3'($urandom);
                @(negedge clk);
            end
            check({tag, "_pvld_early"}, 32'(prod_valid), 32'd0);
            check({tag, "_drdy"}, 32'(dig_ready), 32'd1);
            dig_valid = 1'b1;
            {si, di, ni} = t[k];
            if (noise) begin
                start      = 1'($urandom);
                prod_ready = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            dig_valid  = 1'b0;
            {si, di, ni} = 3'b000;
            start      = 1'b0;
            prod_ready = 1'b0;
        end
        check({tag, "_pvld"}, 32'(prod_valid), 32'd1);
        check({tag, "_prod"}, 32'(prod), 32'(exp_prod));
        check({tag, "_err"},  32'(err), 32'(exp_err));
        check({tag, "_drdy_done"}, 32'(dig_ready), 32'd0);
        held = prod;
        for (int j = 0; j < hold; j++) begin
            dig_valid = 1'b1;
            {si, di, ni} = 3'b100;
            @(negedge clk);
            check({tag, "_hold_pvld"}, 32'(prod_valid), 32'd1);
            check({tag, "_hold_prod"}, 32'(prod), 32'(held));
        end
        dig_valid  = 1'b0;
        {si, di, ni} = 3'b000;
        prod_ready = 1'b1;
        start      = both;
        mcand      = N'($urandom);
        @(posedge clk);
        @(negedge clk);
        prod_ready = 1'b0;
        start      = 1'b0;
        check({tag, "_pvld_after"}, 32'(prod_valid), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_err_after"},  32'(err), 32'(exp_err));
        if (both) begin
            @(negedge clk);
            check({tag, "_start_ignored"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        dig_t        t;
        logic [N-1:0] mc, ml;
        int           p;

        rst_n = 1'b0; start = 1'b0; mcand = '0; dig_valid = 1'b0;
        si = 1'b0; di = 1'b0; ni = 1'b0; prod_ready = 1'b0;
        #1;
        idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_outputs("post_reset");

        // 7 x {-1,+1,0,0} = -7 + 28
        t = {3'b000, 3'b000, 3'b100, 3'b101};
        run_op("basic", 8'd7, t, 16'h0015, 1'b0, 0, 0, 0, 0);

        // Most negative mcand with -2 in the top digit
        t = {3'b011, 3'b000, 3'b000, 3'b000};
        run_op("minneg", 8'h80, t, 16'h4000, 1'b0, 0, 0, 0, 0);

        // Same digits with dig_valid gaps and a 5-cycle output stall
        t = recode(8'hB5);
        p = int'($signed(8'sd93)) * int'($signed(8'hB5));
        run_op("gap0", 8'd93, t, p[15:0], 1'b0, 0, 0, 0, 0);
        run_op("gap1", 8'd93, t, p[15:0], 1'b0, 3, 5, 0, 0);

        // Illegal digit at position 1 and a negative zero at position 2
        t = {3'b100, 3'b001, 3'b110, 3'b101};
        run_op("illegal", 8'd45, t, digit_prod(8'd45, t), 1'b1, 0, 0, 0, 0);
        t = {3'b010, 3'b001, 3'b100, 3'b000};
        run_op("negzero", 8'hE3, t, digit_prod(8'hE3, t), 1'b0, 0, 0, 0, 0);

        // start together with prod_ready in DONE: only the handshake completes
        t = recode(8'd3);
        run_op("both", 8'd11, t, 16'd33, 1'b0, 0, 0, 0, 1);

        // Reset mid-operation
        mcand = 8'd100;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dig_valid = 1'b1;
            {si, di, ni} = (k == 0) ? 3'b010 : 3'b110;
            @(posedge clk);
            @(negedge clk);
        end
        dig_valid = 1'b0;
        {si, di, ni} = 3'b000;
        check("midop_err", 32'(err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        dig_valid = 1'b1;
        {si, di, ni} = 3'b100;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            idle_outputs("nostart");
        end
        dig_valid = 1'b0;
        {si, di, ni} = 3'b000;
        t = recode(8'h9C);
        p = int'($signed(8'h9C)) * int'($signed(8'h27));
        run_op("after_rst", 8'h27, t, p[15:0], 1'b0, 0, 0, 0, 0);

        // Random signed pairs against the arithmetic product
        for (int i = 0; i < 300; i++) begin
            mc = N'($urandom);
            ml = N'($urandom);
            p  = int'($signed(mc)) * int'($signed(ml));
            run_op("rand", mc, recode(ml), p[15:0], 1'b0, 2, int'($urandom_range(0, 3)), 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
